// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: one 64-byte line per bus read, 32-bit issue with redirect
module fetch_unit #(
    parameter int                       BUS_DATA_WIDTH = 64,
    parameter int                       BUS_TAG_WIDTH  = 13,
    parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG       = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    output logic                      bus_reqcyc,
    output logic [63:0]               bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,
    output logic                      inst_valid,
    input  logic                      inst_ready,
    output logic [31:0]               inst,
    output logic [63:0]               inst_pc,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_RESP  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [63:0]               r_pc;
    logic [63:0]               w_pc_next;
    logic [63:0]               r_req_addr;
    logic [2:0]                r_beat;
    logic [2:0]                w_beat_next;
    logic                      r_drop;
    logic                      w_drop_next;
    logic [BUS_DATA_WIDTH-1:0] r_buf [8];
    logic [BUS_DATA_WIDTH-1:0] w_line_word;
    logic                      w_last_beat;
    logic                      w_unused;

    assign w_line_word = r_buf[r_pc[5:3]];
    assign w_last_beat = (r_state == S_RESP) && bus_respcyc && (r_beat == 3'd7);
    assign w_unused    = ^{bus_resptag, entry[1:0], redirect_pc[1:0]};

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_beat_next  = r_beat;
        w_drop_next  = r_drop;
        bus_reqcyc   = 1'b0;
        bus_req      = '0;
        bus_reqtag   = '0;
        bus_respack  = 1'b0;
        inst_valid   = 1'b0;
        inst         = '0;
        inst_pc      = '0;

        case (r_state)
            S_REQ: begin
                bus_reqcyc = 1'b1;
                bus_req    = r_req_addr;
                bus_reqtag = READ_TAG;
                if (bus_reqack) begin
                    w_state_next = S_RESP;
                    w_beat_next  = 3'd0;
                end
            end
            S_RESP: begin
                bus_respack = bus_respcyc;
                if (bus_respcyc) begin
                    w_beat_next = r_beat + 3'd1;
                    if (r_beat == 3'd7) begin
                        // A redirect landing on the final beat makes this line just as stale.
                        if (r_drop || redirect_valid) begin
                            w_state_next = S_REQ;
                            w_drop_next  = 1'b0;
                        end else begin
                            w_state_next = S_ISSUE;
                        end
                    end
                end
            end
            S_ISSUE: begin
                inst_valid = 1'b1;
                inst_pc    = r_pc;
                inst       = r_pc[2] ? w_line_word[63:32] : w_line_word[31:0];
                if (inst_ready) begin
                    w_pc_next = r_pc + 64'd4;
                    if (r_pc[5:2] == 4'hf) begin
                        w_state_next = S_REQ;
                    end
                end
            end
            default: begin
                w_state_next = S_REQ;
            end
        endcase

        if (redirect_valid) begin
            w_pc_next = {redirect_pc[63:2], 2'b00};
            if (r_state == S_ISSUE) begin
                w_state_next = S_REQ;
            end else if (!w_last_beat) begin
                w_drop_next = 1'b1;
            end
        end

        if (!reset) begin
            bus_reqcyc  = 1'b0;
            bus_req     = '0;
            bus_reqtag  = '0;
            bus_respack = 1'b0;
            inst_valid  = 1'b0;
            inst        = '0;
            inst_pc     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_REQ;
            r_pc       <= {entry[63:2], 2'b00};
            r_req_addr <= {entry[63:6], 6'b0};
            r_beat     <= 3'd0;
            r_drop     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_beat  <= w_beat_next;
            r_drop  <= w_drop_next;
            // Latch the line address only on entry to REQ so a pending request never moves.
            if ((w_state_next == S_REQ) && (r_state != S_REQ)) begin
                r_req_addr <= {w_pc_next[63:6], 6'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == S_RESP) && bus_respcyc) begin
            r_buf[r_beat] <= bus_resp;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: vector table, directed redirects, random traffic
module tb_fetch_unit;

    localparam logic [12:0] TAG = 13'h0A5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] entry = '0;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack = 1'b0;
    logic        bus_respcyc = 1'b0;
    logic [63:0] bus_resp = '0;
    logic [12:0] bus_resptag = '0;
    logic        bus_respack;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;

    always #5 clk = ~clk;

    fetch_unit #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .READ_TAG(TAG)) dut (
        .clk(clk), .reset(reset), .entry(entry),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // bus responder and stream model state
    int          bm_phase;
    logic [63:0] bm_addr;
    int          bm_beat;
    int          bm_wait;
    int          ack_delay;
    int          gap_pct;
    int          ready_mode;
    logic        rd_next;
    logic [63:0] rd_pc;
    logic [63:0] exp_pc;
    int          issued;
    logic [63:0] req_log[$];
    logic [63:0] issue_log[$];
    logic        req_pend;
    logic [63:0] req_hold;
    logic        stall_pend;
    logic [31:0] stall_inst;
    logic [63:0] stall_pc;

    typedef struct {
        logic [63:0] entry;
        int          delay;
        int          rmode;
        int          gap;
        int          n_issue;
        logic [63:0] req0;
        logic [63:0] req1;
    } vec_t;

    vec_t vt[5];

    function automatic logic [31:0] mem32(input logic [63:0] a);
        return ((a[31:0] - 32'h1000) >> 1) ^ a[63:32];
    endfunction

    function automatic logic [63:0] req_at(input int i);
        return (req_log.size() > i) ? req_log[i] : 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction

    function automatic logic [63:0] issue_at(input int i);
        return (issue_log.size() > i) ? issue_log[i] : 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic drive();
        case (ready_mode)
            0:       inst_ready = 1'b1;
            1:       inst_ready = (cyc % 2) == 0;
            default: inst_ready = 1'($urandom_range(0, 1));
        endcase
        redirect_valid = rd_next;
        redirect_pc    = rd_pc;
        rd_next        = 1'b0;
        bus_reqack     = bus_reqcyc && (bm_phase == 0) && (bm_wait == 0);
        if (bm_phase == 1) begin
            bus_respcyc = ($urandom_range(0, 99) >= gap_pct);
            bus_resp    = {mem32(bm_addr + 64'(bm_beat * 8 + 4)), mem32(bm_addr + 64'(bm_beat * 8))};
        end else begin
            bus_respcyc = 1'($urandom_range(0, 1));
            bus_resp    = {$urandom, $urandom};
        end
        bus_resptag = 13'($urandom);
    endtask

    task automatic observe();
        chk("reqtag", 64'(bus_reqtag), bus_reqcyc ? 64'(TAG) : 64'd0);
        chk("respack", 64'(bus_respack), 64'((bm_phase == 1) && bus_respcyc));
        if (req_pend) begin
            chk("req_hold_cyc", 64'(bus_reqcyc), 64'd1);
            chk("req_hold_addr", bus_req, req_hold);
        end
        if (stall_pend) begin
            chk("stall_valid", 64'(inst_valid), 64'd1);
            chk("stall_inst", 64'(inst), 64'(stall_inst));
            chk("stall_pc", inst_pc, stall_pc);
        end
        if (inst_valid && inst_ready) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst", 64'(inst), 64'(mem32(exp_pc)));
            issue_log.push_back(inst_pc);
            issued++;
            exp_pc = exp_pc + 64'd4;
        end
        stall_pend = inst_valid && !inst_ready && !redirect_valid;
        stall_inst = inst;
        stall_pc   = inst_pc;
        if (redirect_valid) exp_pc = {redirect_pc[63:2], 2'b00};
        if (bm_phase == 1 && bus_respcyc) begin
            bm_beat++;
            if (bm_beat == 8) begin
                bm_phase = 0;
                bm_wait  = ack_delay;
            end
        end
        req_pend = bus_reqcyc && !bus_reqack;
        req_hold = bus_req;
        if (bus_reqcyc && bus_reqack) begin
            req_log.push_back(bus_req);
            bm_phase = 1;
            bm_addr  = bus_req;
            bm_beat  = 0;
        end else if (bus_reqcyc && bm_wait > 0) begin
            bm_wait--;
        end
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input logic [63:0] e, input int delay);
        entry     = e;
        ack_delay = delay;
        reset     = 1'b0;
        repeat (3) begin
            bus_reqack     = 1'($urandom_range(0, 1));
            bus_respcyc    = 1'($urandom_range(0, 1));
            bus_resp       = {$urandom, $urandom};
            bus_resptag    = 13'($urandom);
            inst_ready     = 1'($urandom_range(0, 1));
            redirect_valid = 1'($urandom_range(0, 1));
            redirect_pc    = {$urandom, $urandom};
            @(negedge clk);
            chk("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
            chk("rst_req", bus_req, 64'd0);
            chk("rst_reqtag", 64'(bus_reqtag), 64'd0);
            chk("rst_respack", 64'(bus_respack), 64'd0);
            chk("rst_valid", 64'(inst_valid), 64'd0);
            chk("rst_inst", 64'(inst), 64'd0);
            chk("rst_inst_pc", inst_pc, 64'd0);
            @(posedge clk);
            #1;
        end
        reset          = 1'b1;
        redirect_valid = 1'b0;
        bus_reqack     = 1'b0;
        bus_respcyc    = 1'b0;
        bm_phase       = 0;
        bm_wait        = delay;
        rd_next        = 1'b0;
        req_pend       = 1'b0;
        stall_pend     = 1'b0;
        exp_pc         = {e[63:2], 2'b00};
        issued         = 0;
        req_log.delete();
        issue_log.delete();
        #1;
        chk("post_rst_reqcyc", 64'(bus_reqcyc), 64'd1);
        chk("post_rst_req", bus_req, {e[63:6], 6'b0});
    endtask

    task automatic wait_req(input int n, input int budget);
        int k = 0;
        while (req_log.size() < n && k < budget) begin
            cycle();
            k++;
        end
        chk("wait_req_timeout", 64'(req_log.size() >= n), 64'd1);
    endtask

    task automatic wait_issued(input int n, input int budget);
        int k = 0;
        while (issued < n && k < budget) begin
            cycle();
            k++;
        end
        chk("wait_issue_timeout", 64'(issued >= n), 64'd1);
    endtask

    task automatic wait_beat(input int b, input int budget);
        int k = 0;
        while (!(bm_phase == 1 && bm_beat == b) && k < budget) begin
            cycle();
            k++;
        end
        chk("wait_beat_timeout", 64'(bm_phase == 1 && bm_beat == b), 64'd1);
    endtask

    initial begin
        vt[0] = '{64'h1000, 2, 0, 0, 16, 64'h1000, 64'h1040};
        vt[1] = '{64'h1038, 2, 0, 0, 2, 64'h1000, 64'h1040};
        vt[2] = '{64'h1000, 1, 1, 40, 16, 64'h1000, 64'h1040};
        vt[3] = '{64'hFFFF_FFFF_FFFF_FFC4, 0, 2, 30, 15, 64'hFFFF_FFFF_FFFF_FFC0, 64'h0};
        vt[4] = '{64'h2006, 3, 0, 0, 15, 64'h2000, 64'h2040};

        rd_next = 1'b0;
        rd_pc   = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            ready_mode = vt[i].rmode;
            gap_pct    = vt[i].gap;
            do_reset(vt[i].entry, vt[i].delay);
            wait_req(2, 600);
            chk("vec_issued", 64'(issued), 64'(vt[i].n_issue));
            chk("vec_req0", req_at(0), vt[i].req0);
            chk("vec_req1", req_at(1), vt[i].req1);
            chk("vec_first_pc", issue_at(0), {vt[i].entry[63:2], 2'b00});
        end

        // redirect while beat 3 is accepted: rest of line drained, nothing issued from it
        ready_mode = 0;
        gap_pct    = 0;
        do_reset(64'h1000, 2);
        wait_beat(3, 100);
        rd_next = 1'b1;
        rd_pc   = 64'h2004;
        cycle();
        wait_req(2, 200);
        chk("rdA_issued", 64'(issued), 64'd0);
        chk("rdA_req1", req_at(1), 64'h2000);
        wait_issued(15, 200);
        chk("rdA_first_pc", issue_at(0), 64'h2004);

        // redirect on the final beat
        do_reset(64'h1000, 1);
        wait_beat(7, 100);
        rd_next = 1'b1;
        rd_pc   = 64'h5000;
        cycle();
        wait_req(2, 200);
        chk("rdL_issued", 64'(issued), 64'd0);
        chk("rdL_req1", req_at(1), 64'h5000);
        wait_issued(1, 200);
        chk("rdL_first_pc", issue_at(0), 64'h5000);

        // redirect with a handshake in ISSUE, then a second redirect while the request waits for ack
        do_reset(64'h1000, 4);
        wait_issued(3, 200);
        rd_next = 1'b1;
        rd_pc   = 64'h3000;
        cycle();
        chk("rdB_hs_counted", 64'(issued), 64'd4);
        cycle();
        rd_next = 1'b1;
        rd_pc   = 64'h400A;
        cycle();
        wait_req(3, 300);
        chk("rdB_req1", req_at(1), 64'h3000);
        chk("rdB_req2", req_at(2), 64'h4000);
        chk("rdB_issued", 64'(issued), 64'd4);
        wait_issued(5, 200);
        chk("rdB_resume_pc", issue_at(4), 64'h4008);

        // random traffic against the stream model
        ready_mode = 2;
        gap_pct    = 30;
        for (int r = 0; r < 4; r++) begin
            do_reset({$urandom, $urandom}, int'($urandom_range(0, 3)));
            for (int k = 0; k < 700; k++) begin
                ack_delay = int'($urandom_range(0, 3));
                if ($urandom_range(0, 49) == 0) begin
                    rd_next = 1'b1;
                    rd_pc   = {$urandom, $urandom};
                end
                cycle();
            end
            chk("rnd_progress", 64'(issued > 0), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
